// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART transmitter
//
// Buffers upstream bytes so a whole result string can be queued without
// waiting on the baud rate, then serialises each byte LSB first with one
// start bit and one stop bit. Frames are sent back to back with no idle gap.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   send      upstream byte valid, sampled every clk
//   ascii_in  byte to queue, sampled with send
//   ready     FIFO can accept a byte this cycle
//   tx        serial line, idle high, registered
//   busy      FIFO non-empty or frame in progress
//   overflow  sticky: a byte was offered while ready was low
//   level     FIFO occupancy, 0..DEPTH

module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [7:0]        ascii_in,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              overflow,
   output logic [ADDR_W:0]   level
);

   localparam int              CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]  LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_idx_nxt;
   logic [7:0]        shift_reg;
   logic [7:0]        shift_nxt;
   logic              tx_nxt;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              bit_done;

   // ready comes only from the registered level, so a push offered while
   // full is refused even if the transmitter pops in that same cycle.
   assign ready      = (level != LEVEL_FULL);
   assign push       = send && ready;
   assign fifo_empty = (level == '0);
   assign bit_done   = (bit_cnt == CNT_LAST);
   assign busy       = (state != S_IDLE) || !fifo_empty;

   // Storage needs no reset; level alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ascii_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (send && !ready) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_nxt;
         tx        <= tx_nxt;
      end
   end

   // tx_nxt is the line value for the cycle after this edge, so each state
   // drives the level of the bit it is about to enter.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift_reg;
      tx_nxt      = tx;
      pop         = 1'b0;

      unique case (state)
         S_IDLE: begin
            tx_nxt = 1'b1;
            if (!fifo_empty) begin
               pop         = 1'b1;
               shift_nxt   = mem[rd_ptr];
               bit_cnt_nxt = '0;
               state_nxt   = S_START;
               tx_nxt      = 1'b0;
            end
         end

         S_START: begin
            if (bit_done) begin
               bit_cnt_nxt = '0;
               bit_idx_nxt = '0;
               state_nxt   = S_DATA;
               tx_nxt      = shift_reg[0];
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_done) begin
               bit_cnt_nxt = '0;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shift_reg[bit_idx + 3'd1];
               end
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (bit_done) begin
               bit_cnt_nxt = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_nxt = mem[rd_ptr];
                  state_nxt = S_START;
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = S_IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered

module tb_uart_tx_buffered;

   localparam int CPB    = 4;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam int FRAME  = 10 * CPB;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              send = 1'b0;
   logic [7:0]        ascii_in = 8'h00;
   logic              ready;
   logic              tx;
   logic              busy;
   logic              overflow;
   logic [ADDR_W:0]   level;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_arr [6];
   logic [7:0] rx_q [$];

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .send     (send),
      .ascii_in (ascii_in),
      .ready    (ready),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow),
      .level    (level)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: byte queue plus the edge index at which the current frame began.
   logic [7:0] mq [$];
   bit         m_active;
   int         m_start;
   logic [7:0] m_byte;
   bit         m_ovf;
   int         cyc;

   function automatic logic model_tx();
      int pos;
      if (!m_active) return 1'b1;
      pos = (cyc - m_start) / CPB;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return m_byte[pos - 1];
   endfunction

   initial begin
      cyc      = 0;
      m_active = 0;
      m_start  = 0;
      m_byte   = 8'h00;
      m_ovf    = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            int pre;
            pre = mq.size();
            cyc++;
            if (m_active && (cyc - m_start == FRAME)) m_active = 0;
            if (!m_active && pre != 0) begin
               m_byte   = mq.pop_front();
               m_active = 1;
               m_start  = cyc;
            end
            if (send) begin
               if (pre != DEPTH) mq.push_back(ascii_in);
               else m_ovf = 1;
            end
         end
         @(negedge clk);
         if (!rst) begin
            mq.delete();
            m_active = 0;
            m_ovf    = 0;
         end
         check("cmp_tx", tx, model_tx());
         check("cmp_level", level, mq.size());
         check("cmp_ready", ready, mq.size() != DEPTH);
         check("cmp_busy", busy, m_active || mq.size() != 0);
         check("cmp_overflow", overflow, m_ovf);
      end
   end

   // Line receiver: samples mid-bit from the detected start edge.
   initial begin
      logic [7:0] b;
      bit         ok;
      int         off;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx === 1'b0) begin
            ok  = 1;
            off = 0;
            b   = 8'h00;
            while (off < FRAME - 1) begin
               @(negedge clk);
               off++;
               if (!rst) begin
                  ok = 0;
                  break;
               end
               if (off >= 6 && off <= 34 && ((off - 6) % CPB) == 0) b[(off - 6) / CPB] = tx;
               if (off == 38) check("rx_stop_bit", tx, 1);
            end
            if (ok) rx_q.push_back(b);
         end
      end
   end

   task automatic drive(input logic s, input logic [7:0] d);
      @(negedge clk);
      #1;
      send     = s;
      ascii_in = d;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic check_rx(input string name, input int n);
      check({name, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n && i < rx_q.size(); i++) check(name, rx_q[i], exp_arr[i]);
      rx_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [9:0] f1;
      int         off;

      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_level", level, 0);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single byte 0x39
      drive(1'b1, 8'h39);
      @(negedge clk);
      check("t1_level_after_push", level, 1);
      check("t1_tx_still_idle", tx, 1);
      #1 send = 1'b0;
      @(negedge clk);
      check("t1_tx_start", tx, 0);
      check("t1_popped", level, 0);
      f1 = 10'b1001110010;
      for (off = 1; off <= FRAME; off++) begin
         @(negedge clk);
         if ((off % CPB) == 2) check("t1_bit", tx, f1[off / CPB]);
         if (off == FRAME - 1) check("t1_busy_last", busy, 1);
         if (off == FRAME) check("t1_idle_after_40", busy, 0);
      end
      exp_arr[0] = 8'h39;
      check_rx("t1_rx", 1);

      // 2: burst "6+3\n"
      exp_arr = '{8'h36, 8'h2B, 8'h33, 8'h0A, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) drive(1'b1, exp_arr[i]);
      drive(1'b0, 8'h00);
      off = 2;
      while (busy !== 1'b0 && off < 400) begin
         @(negedge clk);
         off++;
      end
      check("t2_active_cycles", off, 160);
      check_rx("t2_rx", 4);

      // 3: overflow on the sixth consecutive send
      exp_arr = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            check("t3_level_peak", level, 4);
            check("t3_ready_low", ready, 0);
            check("t3_ovf_clear", overflow, 0);
         end
         #1;
         send     = 1'b1;
         ascii_in = exp_arr[i];
      end
      @(negedge clk);
      check("t3_ovf_set", overflow, 1);
      check("t3_level_kept", level, 4);
      #1 send = 1'b0;
      wait_idle("t3_drain", 400);
      check_rx("t3_rx", 5);

      // 4: send held high while full
      exp_arr = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h5A};
      for (int i = 0; i < 5; i++) drive(1'b1, exp_arr[i]);
      drive(1'b1, 8'h5A);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_ready_held_low", ready, 0);
         check("t4_level_held", level, 4);
      end
      off = 0;
      @(negedge clk);
      while (ready !== 1'b1 && off < 200) begin
         @(negedge clk);
         off++;
      end
      check("t4_ready_back", ready, 1);
      @(negedge clk);
      check("t4_push_resumed", level, 4);
      #1 send = 1'b0;
      wait_idle("t4_drain", 500);
      check_rx("t4_rx", 6);

      // 5: reset during data bit 3 of 0x55
      drive(1'b1, 8'h55);
      drive(1'b0, 8'h00);
      @(negedge clk);
      check("t5_start", tx, 0);
      repeat (17) @(negedge clk);
      check("t5_bit3_low", tx, 0);
      #1 rst = 1'b0;
      #1;
      check("t5_rst_tx", tx, 1);
      check("t5_rst_level", level, 0);
      check("t5_rst_overflow", overflow, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ready", ready, 1);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_idle_busy", busy, 0);
      check("t5_idle_tx", tx, 1);
      rx_q.delete();
      drive(1'b1, 8'h39);
      drive(1'b0, 8'h00);
      wait_idle("t5_drain", 200);
      exp_arr[0] = 8'h39;
      check_rx("t5_rx", 1);

      // 6: push on the cycle the transmitter pops at level 1
      exp_arr = '{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
      drive(1'b1, 8'hC3);
      drive(1'b1, 8'h3C);
      @(negedge clk);
      check("t6_level_stays_1", level, 1);
      #1 send = 1'b0;
      wait_idle("t6_drain", 300);
      check_rx("t6_rx", 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
